// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA opcode, register, math, function, class and literal-state types
package isa_pkg;

  localparam int ISA_IW  = 9;
  localparam int ISA_OPW = 5;

  typedef enum logic [4:0] {
    OP_LITL = 5'd0,  OP_LITH,  OP_MOVC,  OP_MOVD,  OP_MOVE,  OP_MOVF,  OP_MOVG,  OP_MOVH,
    OP_MOVI,         OP_MOVJ,  OP_MOVK,  OP_MOVL,  OP_MOVM,  OP_MOVN,  OP_MOVO,  OP_MOVP,
    OP_LOAD,         OP_STORE, OP_INC,   OP_DEC,   OP_JMP,   OP_JAL,   OP_BZ,    OP_BNZ,
    OP_ZZZZ,         OP_SETH,  OP_MATH,  OP_MATHI, OP_SHL,   OP_SHR,   OP_FLIP,  OP_FUNC
  } op_e;

  typedef enum logic [3:0] {
    R_A, R_B, R_C, R_D, R_E, R_F, R_G, R_H, R_I, R_J, R_K, R_L, R_M, R_N, R_O, R_P
  } reg_e;

  typedef enum logic [3:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOT, M_NEG, M_CMP
  } math_e;

  typedef enum logic [3:0] {
    F_HALT, F_IN, F_OUT, F_NOP
  } func_e;

  typedef enum logic [3:0] {
    C_MOV, C_MEM, C_STEP, C_JUMP, C_BRANCH, C_NOP, C_SETH, C_MATH, C_SHIFT, C_FLIP, C_FUNC
  } op_class_e;

  typedef enum logic [1:0] {
    L_IDLE, L_LO, L_FULL
  } lit_state_e;

endpackage

// File: rtl/decode_skid_buf.sv
// rtl/decode_skid_buf.sv - 2-entry valid/ready skid buffer of parametrised width
module decode_skid_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_s_tdata,
  input  logic         i_s_tvalid,
  output logic         o_s_tready,
  output logic [W-1:0] o_m_tdata,
  output logic         o_m_tvalid,
  input  logic         i_m_tready
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_s_tready = (r_count != 2'd2);
  assign o_m_tvalid = (r_count != 2'd0);
  assign o_m_tdata  = r_mem[r_rd_ptr];
  assign w_push     = i_s_tvalid & o_s_tready;
  assign w_pop      = o_m_tvalid & i_m_tready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_s_tdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode stage: classifier, literal FSM, skid-buffered issue
// Optional DECODE_ILLEGAL_TRAP_EN: drop zzzz and raise sticky out_illegal.
module instr_decode_stage
  import isa_pkg::*;
#(
  parameter int IW   = ISA_IW,
  parameter int OPW  = ISA_OPW,
  parameter int FW   = IW - OPW,
  parameter int LITW = 2 * FW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_op,
  output logic [3:0]      out_class,
  output logic [3:0]      out_dst,
  output logic [FW-1:0]   out_fld,
  output logic [LITW-1:0] out_lit,
  output logic            out_lit_valid,
  output logic            out_illegal
);

  localparam int EW = OPW + 4 + 4 + FW + LITW + 1;

  logic [OPW-1:0]  w_op;
  logic [FW-1:0]   w_fld;
  op_class_e       w_class;
  logic [3:0]      w_dst;
  logic            w_buf_ready;
  logic            w_accept;
  logic            w_enq;
  lit_state_e      r_lit_state;
  lit_state_e      w_lit_next;
  logic [LITW-1:0] r_acc;
  logic [LITW-1:0] w_acc_next;
  logic [EW-1:0]   w_enq_data;
  logic [EW-1:0]   w_deq_data;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            w_trap;
  logic            r_illegal;
`endif

  assign w_op     = in_instr[IW-1 -: OPW];
  assign w_fld    = in_instr[FW-1:0];
  assign in_ready = rst_n & w_buf_ready;
  assign w_accept = in_valid & in_ready;

  // Upper opcode half is grouped in pairs; only 24/25 and 30/31 split by the LSB.
  always_comb begin
    w_class = C_MOV;
    w_dst   = '0;
    if (!w_op[OPW-1]) begin
      w_dst = w_op[3:0];
    end else begin
      case (w_op[3:1])
        3'd0:    w_class = C_MEM;
        3'd1:    w_class = C_STEP;
        3'd2:    w_class = C_JUMP;
        3'd3:    w_class = C_BRANCH;
        3'd4:    w_class = w_op[0] ? C_SETH : C_NOP;
        3'd5:    w_class = C_MATH;
        3'd6:    w_class = C_SHIFT;
        default: w_class = w_op[0] ? C_FUNC : C_FLIP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lit_state <= L_IDLE;
      r_acc       <= '0;
    end else begin
      r_lit_state <= w_lit_next;
      r_acc       <= w_acc_next;
    end
  end

  always_comb begin
    w_lit_next = r_lit_state;
    w_acc_next = r_acc;
    w_enq      = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    w_trap     = 1'b0;
`endif
    if (w_accept) begin
      if (w_op == OP_LITL) begin
        w_acc_next = {{(LITW-FW){1'b0}}, w_fld};
        w_lit_next = L_LO;
      end else if (w_op == OP_LITH) begin
        w_acc_next[LITW-1:FW] = w_fld;
        w_lit_next            = L_FULL;
      end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (w_op == OP_ZZZZ) begin
          w_trap = 1'b1;
        end else begin
          w_enq      = 1'b1;
          w_lit_next = L_IDLE;
        end
`else
        w_enq      = 1'b1;
        w_lit_next = L_IDLE;
`endif
      end
    end
  end

  // The snapshot is the accumulator before this cycle's update.
  assign w_enq_data = {w_op, w_class, w_dst, w_fld, r_acc, (r_lit_state != L_IDLE)};

  decode_skid_buf #(.W(EW)) u_skid (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_s_tdata  (w_enq_data),
    .i_s_tvalid (w_enq),
    .o_s_tready (w_buf_ready),
    .o_m_tdata  (w_deq_data),
    .o_m_tvalid (out_valid),
    .i_m_tready (out_ready)
  );

  assign {out_op, out_class, out_dst, out_fld, out_lit, out_lit_valid} = w_deq_data;

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      r_illegal <= 1'b0;
    else if (w_trap) r_illegal <= 1'b1;
  end
  assign out_illegal = r_illegal;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - self-checking bench for instr_decode_stage
module tb_instr_decode_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_op;
  logic [3:0] out_class;
  logic [3:0] out_dst;
  logic [3:0] out_fld;
  logic [7:0] out_lit;
  logic       out_lit_valid;
  logic       out_illegal;

  int n_pass  = 0;
  int n_total = 0;

  logic [25:0] obs_q[$];
  logic [25:0] exp_q[$];
  logic [7:0]  m_acc     = 8'h00;
  bit          m_lit     = 1'b0;
  bit          m_illegal = 1'b0;

  instr_decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op        (out_op),
    .out_class     (out_class),
    .out_dst       (out_dst),
    .out_fld       (out_fld),
    .out_lit       (out_lit),
    .out_lit_valid (out_lit_valid),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk)
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      obs_q.push_back({out_op, out_class, out_dst, out_fld, out_lit, out_lit_valid});

  function automatic logic [3:0] ref_class(int op);
    if (op < 16)  return 4'd0;
    if (op <= 17) return 4'd1;
    if (op <= 19) return 4'd2;
    if (op <= 21) return 4'd3;
    if (op <= 23) return 4'd4;
    if (op == 24) return 4'd5;
    if (op == 25) return 4'd6;
    if (op <= 27) return 4'd7;
    if (op <= 29) return 4'd8;
    if (op == 30) return 4'd9;
    return 4'd10;
  endfunction

  task automatic model_accept(input logic [8:0] w);
    int         op;
    logic [3:0] f;
    op = int'(w[8:4]);
    f  = w[3:0];
    if (op == 0) begin
      m_acc = {4'h0, f};
      m_lit = 1'b1;
    end else if (op == 1) begin
      m_acc = {f, m_acc[3:0]};
      m_lit = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
    end else if (op == 24) begin
      m_illegal = 1'b1;
`endif
    end else begin
      exp_q.push_back({5'(op), ref_class(op), (op < 16) ? 4'(op) : 4'd0, f, m_acc, m_lit});
      m_lit = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_acc     = 8'h00;
    m_lit     = 1'b0;
    m_illegal = 1'b0;
    exp_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [8:0] w);
    in_valid = 1'b1;
    in_instr = w;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        model_accept(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_total++;
    $display("FAIL send_timeout: word %h never accepted, in_ready=%b required 1", w, in_ready);
    in_valid = 1'b0;
  endtask

  task automatic wait_issue(output logic [25:0] got, output bit ok);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < 60; i++) begin
      if (obs_q.size() > 0) begin
        got = obs_q.pop_front();
        ok  = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready);
    else n_pass++;
    n_total++;
    if ({out_valid, out_lit_valid, out_illegal} !== 3'b000)
      $display("FAIL reset_flags: got %b required 000", {out_valid, out_lit_valid, out_illegal});
    else n_pass++;
    n_total++;
    if ({out_op, out_class, out_dst, out_fld, out_lit} !== 25'd0)
      $display("FAIL reset_data: got %h required 0", {out_op, out_class, out_dst, out_fld, out_lit});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_literal();
    logic [25:0] got, exp;
    bit ok;
    out_ready = 1'b1;
    send(9'h005); send(9'h01A); send(9'h103);
    while (exp_q.size() > 0) begin
      wait_issue(got, ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok) $display("FAIL literal_issue: timeout, required %h", exp);
      else if (got !== exp) $display("FAIL literal_issue: got %h required %h", got, exp);
      else n_pass++;
      n_total++;
      if (ok && got !== {5'd16, 4'd1, 4'd0, 4'd3, 8'hA5, 1'b1})
        $display("FAIL literal_a5: got %h required %h", got, {5'd16, 4'd1, 4'd0, 4'd3, 8'hA5, 1'b1});
      else if (ok) n_pass++;
    end
    repeat (4) @(negedge clk);
    n_total++;
    if (obs_q.size() != 0) $display("FAIL literal_single_issue: got %0d extra issues required 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_lit_clear();
    logic [25:0] got, exp;
    bit ok;
    send(9'h005); send(9'h103); send(9'h104);
    while (exp_q.size() > 0) begin
      wait_issue(got, ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok) $display("FAIL lit_clear_issue: timeout, required %h", exp);
      else if (got !== exp) $display("FAIL lit_clear_issue: got %h required %h", got, exp);
      else n_pass++;
    end
    n_total++;
    if (got[8:0] !== {8'h05, 1'b0}) $display("FAIL lit_clear_second: got lit/valid %h required 00a", got[8:0]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mov();
    logic [25:0] got, exp;
    bit ok;
    send(9'h0F7);
    @(negedge clk);
    n_total++;
    if ({out_valid, out_class, out_dst, out_fld} !== {1'b1, 4'd0, 4'd15, 4'd7})
      $display("FAIL mov_latency: got v/cls/dst/fld %b/%0d/%0d/%0d required 1/0/15/7",
               out_valid, out_class, out_dst, out_fld);
    else n_pass++;
    wait_issue(got, ok);
    exp = exp_q.pop_front();
    n_total++;
    if (!ok) $display("FAIL mov_issue: timeout, required %h", exp);
    else if (got !== exp) $display("FAIL mov_issue: got %h required %h", got, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [25:0] got, exp;
    bit ok;
    out_ready = 1'b0;
    send(9'h120); send(9'h121);
    in_valid = 1'b1; in_instr = 9'h122;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", in_ready);
      else n_pass++;
      n_total++;
      if ({out_valid, out_op, out_fld} !== {1'b1, 5'd18, 4'd0})
        $display("FAIL bp_hold: got v/op/fld %b/%0d/%0d required 1/18/0", out_valid, out_op, out_fld);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(9'h122);
    while (exp_q.size() > 0) begin
      wait_issue(got, ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok) $display("FAIL bp_order: timeout, required %h", exp);
      else if (got !== exp) $display("FAIL bp_order: got %h required %h", got, exp);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    n_total++;
    if (obs_q.size() != 0) $display("FAIL bp_duplicate: got %0d extra issues required 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_zzzz();
    logic [25:0] got, exp;
    bit ok;
    send(9'h003); send(9'h180); send(9'h150);
    while (exp_q.size() > 0) begin
      wait_issue(got, ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok) $display("FAIL zzzz_issue: timeout, required %h", exp);
      else if (got !== exp) $display("FAIL zzzz_issue: got %h required %h", got, exp);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    n_total++;
    if (obs_q.size() != 0) $display("FAIL zzzz_extra: got %0d extra issues required 0", obs_q.size());
    else n_pass++;
    n_total++;
    if (out_illegal !== m_illegal) $display("FAIL zzzz_illegal: got %b required %b", out_illegal, m_illegal);
    else n_pass++;
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [25:0] got, exp, prev_data, cur;
    bit ok;
    bit prev_stall = 1'b0;
    int op;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = $urandom_range(0, 9);
      op        = (op <= 1) ? 0 : (op == 2) ? 1 : $urandom_range(2, 31);
      in_instr  = {5'(op), 4'($urandom_range(0, 15))};
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready === 1'b1) model_accept(in_instr);
      cur = {out_op, out_class, out_dst, out_fld, out_lit, out_lit_valid};
      if (prev_stall) begin
        n_total++;
        if (out_valid !== 1'b1 || cur !== prev_data)
          $display("FAIL rand_hold: got v=%b %h required v=1 %h", out_valid, cur, prev_data);
        else n_pass++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data  = cur;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      wait_issue(got, ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok) $display("FAIL rand_issue: timeout, required %h", exp);
      else if (got !== exp) $display("FAIL rand_issue: got %h required %h", got, exp);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    n_total++;
    if (obs_q.size() != 0) $display("FAIL rand_extra: got %0d extra issues required 0", obs_q.size());
    else n_pass++;
    n_total++;
    if (out_illegal !== m_illegal) $display("FAIL rand_illegal: got %b required %b", out_illegal, m_illegal);
    else n_pass++;
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    logic [25:0] got, exp;
    bit ok;
    out_ready = 1'b0;
    send(9'h005); send(9'h130); send(9'h00C);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_lit_valid, out_lit, out_illegal} !== 11'd0)
      $display("FAIL midreset_outputs: got %h required 0", {out_valid, out_lit_valid, out_lit, out_illegal});
    else n_pass++;
    obs_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(9'h140);
    wait_issue(got, ok);
    exp = exp_q.pop_front();
    n_total++;
    if (!ok) $display("FAIL midreset_issue: timeout, required %h", exp);
    else if (got !== exp) $display("FAIL midreset_issue: got %h required %h", got, exp);
    else n_pass++;
    n_total++;
    if (got[8:0] !== 9'h000) $display("FAIL midreset_lit: got lit/valid %h required 000", got[8:0]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_literal();
    test_lit_clear();
    test_mov();
    test_backpressure();
    test_zzzz();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
